// File: rtl/arb_rr_4ch.sv
// arb_rr_4ch -- four-channel round-robin arbiter with a one-deep registered output.
//
// Each cycle the arbiter picks one requesting channel and copies its payload
// into an output register. The channel at the round-robin pointer has highest
// priority. After a grant the pointer moves to the channel just after the winner.
//
// Parameters
//   DATA_WIDTH  width of each channel payload (default 32)
//
// Ports
//   i_clk      single clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_vld      per-channel request valid, bit k = channel k
//   i_val      per-channel payload, index k = channel k
//   o_rdy_up   per-channel accept, one-hot or zero, combinational
//   o_vld      output payload valid
//   i_rdy      downstream accept
//   o_key      registered channel index of o_val
//   o_val      registered payload of the granted channel
//   o_cnt      per-channel saturating grant counters (only with ARB_RR_4CH_CNT_EN)
//
// Build option
//   ARB_RR_4CH_CNT_EN  when defined, adds the o_cnt port and the grant counters.

module arb_rr_4ch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [3:0]                 i_vld,
  input  logic [3:0][DATA_WIDTH-1:0] i_val,
  output logic [3:0]                 o_rdy_up,
  output logic                       o_vld,
  input  logic                       i_rdy,
  output logic [1:0]                 o_key,
  output logic [DATA_WIDTH-1:0]      o_val
`ifdef ARB_RR_4CH_CNT_EN
  ,
  output logic [3:0][15:0]           o_cnt
`endif
);

  logic [1:0] ptr;
  logic [1:0] gnt;
  logic [1:0] idx;
  logic       found;
  logic       load;

  // The output register accepts a new word when it is empty or being drained.
  // The reset term keeps o_rdy_up at zero while reset is asserted.
  always_comb begin
    load     = i_rst_n && (!o_vld || i_rdy) && (|i_vld);
    gnt      = 2'd0;
    found    = 1'b0;
    idx      = ptr;
    // The search runs from offset 0 (highest priority) to offset 3. Only the
    // first requester found is kept.
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && i_vld[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    o_rdy_up = load ? (4'b0001 << gnt) : 4'b0000;
  end

  // The registers are written only from registered state and the load decision.
  // i_rdy acts only through load, so it never reaches the outputs in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_vld <= 1'b0;
      o_key <= 2'd0;
      o_val <= '0;
      ptr   <= 2'd0;
    end else if (load) begin
      o_vld <= 1'b1;
      o_key <= gnt;
      o_val <= i_val[gnt];
      ptr   <= gnt + 2'd1;
    end else if (o_vld && i_rdy) begin
      o_vld <= 1'b0;
    end
  end

`ifdef ARB_RR_4CH_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load && (gnt == 2'(k)) && (o_cnt[k] != 16'hFFFF)) begin
          o_cnt[k] <= o_cnt[k] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_arb_rr_4ch.sv
// Testbench for arb_rr_4ch. It runs directed scenarios and then random
// traffic. A behavioural model of the arbitration rules supplies the
// expected values.

module tb_arb_rr_4ch;

  logic              i_clk;
  logic              i_rst_n;
  logic [3:0]        i_vld;
  logic [3:0][31:0]  i_val;
  logic [3:0]        o_rdy_up;
  logic              o_vld;
  logic              i_rdy;
  logic [1:0]        o_key;
  logic [31:0]       o_val;
`ifdef ARB_RR_4CH_CNT_EN
  logic [3:0][15:0]  o_cnt;
`endif

  arb_rr_4ch #(.DATA_WIDTH(32)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_vld    (i_vld),
    .i_val    (i_val),
    .o_rdy_up (o_rdy_up),
    .o_vld    (o_vld),
    .i_rdy    (i_rdy),
    .o_key    (o_key),
    .o_val    (o_val)
`ifdef ARB_RR_4CH_CNT_EN
    ,
    .o_cnt    (o_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  bit          m_vld = 0;
  int          m_key = 0;
  logic [31:0] m_val = '0;
  int          m_ptr = 0;
  int          m_cnt [4] = '{0, 0, 0, 0};
  bit          chk_regs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one clock cycle with the given inputs. The task checks the
  // combinational accept before the edge, checks the registered state at the
  // negedge, and then advances the model.
  task automatic cycle(input logic [3:0] vld, input logic rdy, input logic rst);
    bit   load;
    int   g;
    bit   found;
    logic [3:0] exp_rdy;
    i_vld   = vld;
    i_rdy   = rdy;
    i_rst_n = rst;
    load    = rst && (!m_vld || rdy) && (vld != 4'b0);
    g       = 0;
    found   = 0;
    for (int i = 0; i < 4; i++) begin
      if (!found && vld[(m_ptr + i) % 4]) begin
        found = 1;
        g     = (m_ptr + i) % 4;
      end
    end
    exp_rdy = load ? 4'(1 << g) : 4'b0000;
    @(negedge i_clk);
    chk("rdy_up", 64'(o_rdy_up), 64'(exp_rdy));
    if (chk_regs) begin
      chk("o_vld", 64'(o_vld), 64'(m_vld));
      chk("o_key", 64'(o_key), 64'(m_key));
      chk("o_val", 64'(o_val), 64'(m_val));
`ifdef ARB_RR_4CH_CNT_EN
      for (int k = 0; k < 4; k++) chk("o_cnt", 64'(o_cnt[k]), 64'(m_cnt[k]));
`endif
    end
    @(posedge i_clk);
    #1;
    if (!rst) begin
      m_vld = 0; m_key = 0; m_val = '0; m_ptr = 0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      chk_regs = 1;
    end else if (load) begin
      m_vld = 1;
      m_key = g;
      m_val = i_val[g];
      m_ptr = (g + 1) % 4;
      if (m_cnt[g] < 65535) m_cnt[g] = m_cnt[g] + 1;
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_vld   = 4'h0;
    i_rdy   = 1'b0;
    for (int k = 0; k < 4; k++) i_val[k] = 32'hA0 + 32'(k);

    // Reset with every channel requesting
    cycle(4'hF, 1'b1, 1'b0);
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_key", 64'(o_key), 64'd0);
    chk("rst_val", 64'(o_val), 64'd0);

    // Fairness with every channel requesting and no bubbles
    for (int c = 0; c < 8; c++) begin
      cycle(4'hF, 1'b1, 1'b1);
      chk("fair_vld", 64'(o_vld), 64'd1);
      chk("fair_key", 64'(o_key), 64'(c % 4));
      chk("fair_val", 64'(o_val), 64'(32'hA0 + 32'(c % 4)));
    end

    // Skip and wrap: grant ch2 first, then channels 0 and 1 requesting
    cycle(4'h0, 1'b1, 1'b0);
    cycle(4'b0100, 1'b1, 1'b1);
    chk("skip_key2", 64'(o_key), 64'd2);
    cycle(4'b0011, 1'b1, 1'b1);
    chk("wrap_key0", 64'(o_key), 64'd0);
    cycle(4'b0011, 1'b1, 1'b1);
    chk("wrap_key1", 64'(o_key), 64'd1);
    cycle(4'b0100, 1'b1, 1'b1);
    chk("ptr2_key", 64'(o_key), 64'd2);

    // Stall: ch1 is held in the output register while i_rdy is low
    cycle(4'h0, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(4'hF, 1'b0, 1'b1);
      chk("stall_key", 64'(o_key), 64'd1);
      chk("stall_val", 64'(o_val), 64'hA1);
    end
    cycle(4'hF, 1'b1, 1'b1);
    chk("unstall_key", 64'(o_key), 64'd2);

    // Drain: a single ch3 word, then no requests
    cycle(4'h0, 1'b1, 1'b0);
    i_val[3] = 32'hDEAD_BEEF;
    cycle(4'b1000, 1'b1, 1'b1);
    chk("drain_vld", 64'(o_vld), 64'd1);
    chk("drain_key", 64'(o_key), 64'd3);
    chk("drain_val", 64'(o_val), 64'hDEAD_BEEF);
    cycle(4'h0, 1'b1, 1'b1);
    chk("drain_empty", 64'(o_vld), 64'd0);
    cycle(4'h0, 1'b1, 1'b1);

    // Reset during a transfer drops the held word
    cycle(4'hF, 1'b0, 1'b1);
    cycle(4'hF, 1'b0, 1'b0);
    cycle(4'h0, 1'b1, 1'b1);
    chk("rst_mid_vld", 64'(o_vld), 64'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) i_val[k] = $urandom;
      cycle(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
    end

`ifdef ARB_RR_4CH_CNT_EN
    // Counter saturation with ch0 granted on every cycle
    cycle(4'h0, 1'b1, 1'b0);
    for (int c = 0; c < 70000; c++) cycle(4'b0001, 1'b1, 1'b1);
    chk("cnt0_sat", 64'(o_cnt[0]), 64'hFFFF);
    for (int k = 1; k < 4; k++) chk("cnt_zero", 64'(o_cnt[k]), 64'd0);
    cycle(4'b0001, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) chk("cnt_rst", 64'(o_cnt[k]), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arb_rr_4ch.md
ARB_RR_4CH -- requirements
Module: arb_rr_4ch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each channel payload.
REQ-002 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have i_rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have i_vld  input  4  per-channel request valid, bit k = channel k.
REQ-005 SHALL have i_val  input  [3:0][DATA_WIDTH-1:0]  per-channel payload, packed array, index k = channel k.
REQ-006 SHALL have o_rdy_up  output  4  per-channel accept, one-hot or zero.
REQ-007 SHALL have o_vld  output  1  output payload valid.
REQ-008 SHALL have i_rdy  input  1  downstream accept.
REQ-009 SHALL have o_key  output  2  registered channel index of o_val; drives downstream 4-to-1 mux select.
REQ-010 SHALL have o_val  output  DATA_WIDTH  registered payload of the granted channel.
REQ-011 SHALL have o_cnt  output  [3:0][15:0]  per-channel grant counters, present only with ARB_RR_4CH_CNT_EN.

Function
REQ-012 SHALL hold a 2-bit round-robin pointer ptr; channel ptr has highest priority, then ptr+1, ptr+2, ptr+3, all mod 4.
REQ-013 SHALL define load = (!o_vld || i_rdy) && (|i_vld).
REQ-014 SHALL, when load, grant the first valid channel g in priority order; o_rdy_up = one-hot(g), combinational in the same cycle.
REQ-015 SHALL drive o_rdy_up = 4'b0000 whenever load is 0.
REQ-016 SHALL, on a load edge, register o_val <= i_val[g], o_key <= g, o_vld <= 1, ptr <= g+1 mod 4 (3 wraps to 0).
REQ-017 SHALL, when o_vld && i_rdy && !(|i_vld), clear o_vld on next edge; o_key, o_val hold.
REQ-018 SHALL, when o_vld && !i_rdy, hold o_vld, o_key, o_val, ptr unchanged (stall); no channel accepted.
REQ-019 SHALL support back-to-back transfers: with i_rdy=1 and continuous requests, one grant per cycle, zero bubbles.
REQ-020 SHALL have latency of exactly 1 cycle from channel handshake (i_vld[k] && o_rdy_up[k]) to o_vld with that payload.
REQ-021 SHALL leave ptr unchanged in any cycle without a grant.
REQ-022 SHALL never grant a channel with i_vld[k]=0; a sole requester is granted regardless of ptr.
REQ-023 Upstream SHALL hold i_val[k] stable while i_vld[k] && !o_rdy_up[k]; arbiter relies on this, no checking.
REQ-024 SHALL contain no combinational path from i_rdy to o_vld/o_key/o_val.

Reset
REQ-025 SHALL, on rising edge with i_rst_n=0, set o_vld=0, o_key=2'b00, o_val=0, ptr=0, o_cnt all 0.
REQ-026 SHALL force o_rdy_up=4'b0000 while i_rst_n=0, irrespective of i_vld.
REQ-027 SHALL discard any registered payload when reset asserts mid-transfer; no replay after reset.

Configuration
REQ-028 SHALL, with macro ARB_RR_4CH_CNT_EN defined, include o_cnt: counter k increments by 1 on each grant of channel k, saturating at 16'hFFFF.
REQ-029 SHALL, without ARB_RR_4CH_CNT_EN, omit o_cnt port and counter logic; all other behaviour identical.

Verification
REQ-030 Reset: i_rst_n=0 one cycle with i_vld=4'hF -> o_rdy_up=0; after edge o_vld=0, o_key=0, o_val=0, o_cnt all 0.
REQ-031 Fairness: i_vld=4'hF, i_rdy=1, i_val[k]=32'hA0+k for 8 cycles -> o_key sequence 0,1,2,3,0,1,2,3 with o_val 32'hA0..A3 repeating, no bubbles.
REQ-032 Skip/wrap: ptr=3 after granting ch2, i_vld=4'b0011 -> ch0 granted (o_key=0), then ch1 (o_key=1), ptr=2.
REQ-033 Stall: o_vld=1, o_key=1, i_rdy=0 for 3 cycles with i_vld=4'hF -> o_rdy_up=0, o_key/o_val constant; i_rdy=1 -> ch2 granted same cycle, o_key=2 next cycle.
REQ-034 Drain: single request ch3 val 32'hDEAD_BEEF, then i_vld=0, i_rdy=1 -> o_vld=1 o_key=3 o_val=32'hDEAD_BEEF for one cycle, then o_vld=0.
REQ-035 Counter (ARB_RR_4CH_CNT_EN): 70000 continuous grants of ch0 only -> o_cnt[0]=16'hFFFF, o_cnt[1..3]=0; mid-run reset -> all 0.
